serial_frame_tx: RTL

Parametrised parallel-to-serial frame transmitter and the successor to the fixed 8-bit shift-out block. It accepts words over a valid/ready handshake and frames each one as start bit, data bits, optional parity and 1–2 stop bits, with a programmable bit period and selectable bit order. A one-word holding register allows back-to-back frames with no idle gap. It sits between a byte or word producer and the serial line of the serial network.

---
 rtl/serial_frame_tx.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit, data bits, optional parity, 1-2 stop bits.
// A one-word holding register lets a second word queue up so frames go out back-to-back.
module serial_frame_tx #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned MSB_FIRST    = 1
) (
    input  logic                  dataClk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] parallelDataIn,
    input  logic                  dataValid,
    output logic                  dataReady,
    output logic                  serialDataOut,
    output logic                  busy,
    output logic                  frameDone
);

    if (PARITY > 2) begin : g_bad_parity
        $fatal(1, "serial_frame_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $fatal(1, "serial_frame_tx: STOP_BITS must be 1 or 2");
    end
    if (DATA_WIDTH < 1 || DATA_WIDTH > 16) begin : g_bad_width
        $fatal(1, "serial_frame_tx: DATA_WIDTH must be 1..16");
    end
    if (CLKS_PER_BIT < 1) begin : g_bad_cpb
        $fatal(1, "serial_frame_tx: CLKS_PER_BIT must be >= 1");
    end

    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BitW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [BaudW-1:0] BaudMax = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0]  DataMax = BitW'(DATA_WIDTH - 1);
    localparam logic [BitW-1:0]  StopMax = BitW'(STOP_BITS - 1);
    localparam logic             OddPar  = (PARITY == 2);
    localparam logic             HasPar  = (PARITY != 0);

    typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

    state_e                state_q, state_d;
    logic [BaudW-1:0]      baud_q, baud_d;
    logic [BitW-1:0]       bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  par_q, par_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic                  line_q, line_d;

    logic handshake;
    logic baud_wrap;
    logic frame_end;

    assign handshake = dataValid && !hold_full_q;
    assign baud_wrap = (baud_q == BaudMax);
    assign frame_end = (state_q == StStop) && baud_wrap && (bit_q == StopMax);

    always_ff @(posedge dataClk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            baud_q      <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            par_q       <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            line_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            line_q      <= line_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_wrap ? '0 : baud_q + 1'b1;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        par_d       = par_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        unique case (state_q)
            StIdle: begin
                baud_d = '0;
                bit_d  = '0;
                if (handshake) begin
                    shreg_d = parallelDataIn;
                    par_d   = (^parallelDataIn) ^ OddPar;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_wrap) begin
                    state_d = StData;
                    bit_d   = '0;
                end
            end
            StData: begin
                if (baud_wrap) begin
                    if (bit_q == DataMax) begin
                        state_d = HasPar ? StPar : StStop;
                        bit_d   = '0;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shreg_d = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
                    end
                end
            end
            StPar: begin
                if (baud_wrap) begin
                    state_d = StStop;
                    bit_d   = '0;
                end
            end
            StStop: begin
                if (baud_wrap) begin
                    if (bit_q == StopMax) begin
                        bit_d = '0;
                        if (hold_full_q) begin
                            shreg_d     = hold_q;
                            par_d       = (^hold_q) ^ OddPar;
                            hold_full_d = 1'b0;
                            state_d     = StStart;
                        end else if (handshake) begin
                            // A word offered on the final stop cycle goes straight out next.
                            shreg_d = parallelDataIn;
                            par_d   = (^parallelDataIn) ^ OddPar;
                            state_d = StStart;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (handshake && (state_q != StIdle) && !frame_end) begin
            hold_d      = parallelDataIn;
            hold_full_d = 1'b1;
        end
    end

    // The line register is loaded with the level of the next state, so it changes on the edge.
    always_comb begin
        unique case (state_d)
            StIdle:  line_d = 1'b1;
            StStart: line_d = 1'b0;
            StData:  line_d = (MSB_FIRST != 0) ? shreg_d[DATA_WIDTH-1] : shreg_d[0];
            StPar:   line_d = par_d;
            StStop:  line_d = 1'b1;
            default: line_d = 1'b1;
        endcase
        dataReady     = !hold_full_q;
        busy          = (state_q != StIdle);
        frameDone     = frame_end;
        serialDataOut = line_q;
    end

endmodule
